fifo_uart_tx: RTL and testbench

Downstream drain stage for the team's synchronous FIFO. It pops one word at a time from the FIFO's show-ahead read port, where read data is valid whenever the FIFO is not empty and a pop takes effect at the clock edge. Each word is serialised as an asynchronous UART frame on a single tx line. Frames are sent back-to-back with zero idle gap while the FIFO holds data and the block is enabled.

---
 rtl/fifo_uart_pkg.sv | 26 ++
 rtl/uart_baud_tick.sv | 33 +++
 rtl/fifo_uart_tx.sv | 117 +++++++++++
 tb/tb_fifo_uart_tx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared types and helpers for the FIFO-drain UART transmitter.
//   tx_state_e : transmitter frame state
//   cnt_width  : bit-period counter width for a given CLKS_PER_BIT
//   frame_len  : clk cycles from one pop edge to the next possible pop edge
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  function automatic int unsigned cnt_width(input int unsigned clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

  function automatic int unsigned frame_len(input int unsigned data_width,
                                            input int unsigned clks_per_bit,
                                            input int unsigned parity_en,
                                            input int unsigned stop_bits);
    return (1 + data_width + parity_en + stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running bit-period counter.
//   clk, reset_n : clock, async active-low reset
//   restart      : force the count back to 0 on the next edge
//   tick         : high while the count is CLKS_PER_BIT-1 (last clk of a bit)
module uart_baud_tick
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CntW = cnt_width(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] count_q;

  assign tick = (count_q == CntMax);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (restart || tick) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CntW'(1);
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a show-ahead FIFO one word at a time onto a UART tx line.
//   clk, reset_n  : clock, async active-low reset
//   enable        : permits new pops; an in-flight frame always completes
//   fifo_empty    : FIFO empty flag
//   fifo_rd_data  : FIFO head word, valid while fifo_empty=0
//   fifo_rd_en    : pop strobe (combinational)
//   tx            : serial line, registered, idles high
//   busy          : frame in progress
//   frame_done    : pulse in the last clk of the final stop bit
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_WIDTH - 1);
  localparam logic LastStop = (STOP_BITS == 2);

  tx_state_e             state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  parity_q;
  logic [IdxW-1:0]       bit_idx_q;
  logic                  stop_idx_q;

  logic bit_tick;
  logic last_stop_cycle;
  logic pop;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset_n(reset_n),
    .restart(pop),
    .tick   (bit_tick)
  );

  assign last_stop_cycle = (state_q == StStop) && bit_tick && (stop_idx_q == LastStop);
  // Chaining: a pop in the final stop cycle starts the next frame with no idle gap.
  assign pop        = enable && !fifo_empty && ((state_q == StIdle) || last_stop_cycle);
  // The state flops are already held in reset; gating here only keeps the FIFO untouched.
  assign fifo_rd_en = pop && reset_n;
  assign busy       = (state_q != StIdle);
  assign frame_done = last_stop_cycle;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      tx         <= 1'b1;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
    end else if (pop) begin
      state_q    <= StStart;
      tx         <= 1'b0;
      shift_q    <= fifo_rd_data;
      parity_q   <= (^fifo_rd_data) ^ PARITY_ODD;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
    end else if (bit_tick) begin
      unique case (state_q)
        StIdle: ;
        StStart: begin
          tx      <= shift_q[0];
          shift_q <= shift_q >> 1;
          state_q <= StData;
        end
        StData: begin
          if (bit_idx_q == LastIdx) begin
            bit_idx_q <= '0;
            if (PARITY_EN) begin
              state_q <= StParity;
              tx      <= parity_q;
            end else begin
              state_q <= StStop;
              tx      <= 1'b1;
            end
          end else begin
            bit_idx_q <= bit_idx_q + IdxW'(1);
            tx        <= shift_q[0];
            shift_q   <= shift_q >> 1;
          end
        end
        StParity: begin
          state_q <= StStop;
          tx      <= 1'b1;
        end
        StStop: begin
          if (stop_idx_q == LastStop) begin
            state_q    <= StIdle;
            stop_idx_q <= 1'b0;
          end else begin
            stop_idx_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: four instances with different framing options share enable/reset,
// each fed from its own FIFO model. Words are pushed to a scoreboard when written; each pop
// starts a per-cycle check of the tx waveform against the expected frame.
module tb_fifo_uart_tx;

  localparam int NI = 4;
  // Per-instance options: inst0 plain, inst1 even parity, inst2 odd parity + 2 stop, inst3 2 stop
  localparam bit [3:0] PE = 4'b0110;
  localparam bit [3:0] PO = 4'b0100;
  localparam bit [3:0] S2 = 4'b1100;
  localparam int CPB = 4;

  int flen [NI] = '{40, 44, 48, 44};

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [3:0] empty;
  logic [3:0] rd_en;
  logic [3:0] txv;
  logic [3:0] busy;
  logic [3:0] done;
  logic [7:0] rd_data [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    fifo_uart_tx #(
      .DATA_WIDTH  (8),
      .CLKS_PER_BIT(CPB),
      .PARITY_EN   (PE[g]),
      .PARITY_ODD  (PO[g]),
      .STOP_BITS   (S2[g] ? 2 : 1)
    ) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .enable      (enable),
      .fifo_empty  (empty[g]),
      .fifo_rd_data(rd_data[g]),
      .fifo_rd_en  (rd_en[g]),
      .tx          (txv[g]),
      .busy        (busy[g]),
      .frame_done  (done[g])
    );
  end

  logic [7:0] fq  [NI][$];
  logic [7:0] sbq [NI][$];
  bit         active [NI];
  int         c [NI];
  logic [7:0] cur [NI];
  int         pops [NI];
  int         total = 0;
  int         bad = 0;

  typedef struct {
    bit         en;
    int         nw;
    logic [7:0] w0;
    logic [7:0] w1;
    int         cycles;
    int         exp_pops;
  } vec_t;

  task automatic chk(input string nm, input int i, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, i, $time, act, exp);
    end
  endtask

  function automatic logic exp_tx(input int i, input logic [7:0] w, input int cc);
    int b;
    b = (cc - 1) / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return w[b-1];
    if (PE[i] && b == 9) return (^w) ^ PO[i];
    return 1'b1;
  endfunction

  task automatic update_fifo(input int i);
    empty[i]   = (fq[i].size() == 0);
    rd_data[i] = empty[i] ? 8'h00 : fq[i][0];
  endtask

  task automatic write_all(input logic [7:0] w);
    for (int i = 0; i < NI; i++) begin
      fq[i].push_back(w);
      sbq[i].push_back(w);
      update_fifo(i);
    end
  endtask

  // One clock: check outputs mid-cycle, then apply pops to the FIFO models after the edge.
  task automatic step();
    logic [3:0] rd_s;
    logic       exp_pop;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      if (active[i]) begin
        c[i]++;
        chk("tx_bit", i, int'(txv[i]), int'(exp_tx(i, cur[i], c[i])));
        chk("busy_frame", i, int'(busy[i]), 1);
        chk("frame_done", i, int'(done[i]), int'(c[i] == flen[i]));
      end else begin
        chk("tx_idle", i, int'(txv[i]), 1);
        chk("busy_idle", i, int'(busy[i]), 0);
        chk("done_idle", i, int'(done[i]), 0);
      end
      exp_pop = reset_n && enable && (fq[i].size() > 0) && (!active[i] || c[i] == flen[i]);
      chk("rd_en", i, int'(rd_en[i]), int'(exp_pop));
      rd_s[i] = rd_en[i];
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      if (active[i] && c[i] == flen[i]) active[i] = 1'b0;
      if (rd_s[i]) begin
        chk("pop_nonempty", i, int'(fq[i].size() > 0), 1);
        if (fq[i].size() > 0) begin
          void'(fq[i].pop_front());
          cur[i] = sbq[i].pop_front();
        end
        active[i] = 1'b1;
        c[i]      = 0;
        pops[i]++;
      end
      update_fifo(i);
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic clear_pops();
    for (int i = 0; i < NI; i++) pops[i] = 0;
  endtask

  task automatic check_pops(input string nm, input int exp);
    for (int i = 0; i < NI; i++) chk(nm, i, pops[i], exp);
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{en: 1'b1, nw: 1, w0: 8'hA5, w1: 8'h00, cycles: 110, exp_pops: 1};
    vecs[1] = '{en: 1'b1, nw: 2, w0: 8'h3C, w1: 8'hC3, cycles: 110, exp_pops: 2};
    vecs[2] = '{en: 1'b1, nw: 1, w0: 8'h07, w1: 8'h00, cycles: 60, exp_pops: 1};
    vecs[3] = '{en: 1'b0, nw: 1, w0: 8'h55, w1: 8'h00, cycles: 60, exp_pops: 0};
    vecs[4] = '{en: 1'b1, nw: 0, w0: 8'h00, w1: 8'h00, cycles: 60, exp_pops: 1};
    vecs[5] = '{en: 1'b1, nw: 2, w0: 8'hFF, w1: 8'h00, cycles: 110, exp_pops: 2};

    reset_n = 1'b0;
    enable  = 1'b0;
    for (int i = 0; i < NI; i++) begin
      active[i] = 1'b0;
      c[i]      = 0;
      cur[i]    = 8'h00;
      update_fifo(i);
    end
    clear_pops();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("rst_tx", i, int'(txv[i]), 1);
      chk("rst_busy", i, int'(busy[i]), 0);
      chk("rst_done", i, int'(done[i]), 0);
    end
    // A pending word with enable high must not pop while reset is held.
    enable = 1'b1;
    write_all(8'h11);
    run(3);
    check_pops("no_pop_in_reset", 0);
    reset_n = 1'b1;
    run(60);
    check_pops("pop_after_reset", 1);

    foreach (vecs[v]) begin
      clear_pops();
      enable = vecs[v].en;
      if (vecs[v].nw > 0) write_all(vecs[v].w0);
      if (vecs[v].nw > 1) write_all(vecs[v].w1);
      run(vecs[v].cycles);
      check_pops($sformatf("vec%0d_pops", v), vecs[v].exp_pops);
    end

    // enable falls at cycle 10 of a frame: that frame completes, the second word stays queued.
    clear_pops();
    enable = 1'b1;
    write_all(8'h81);
    write_all(8'h18);
    run(10);
    enable = 1'b0;
    run(60);
    check_pops("enable_fall_pops", 1);
    enable = 1'b1;
    run(60);
    check_pops("enable_resume_pops", 2);

    // FIFO empties at end of frame; a new word 3 cycles after dut0 finishes pops immediately.
    clear_pops();
    write_all(8'h96);
    run(43);
    write_all(8'h69);
    run(60);
    check_pops("late_write_pops", 2);

    // Async reset at cycle 17 of an 0xA5 frame; 0x5A follows from a fresh start bit.
    clear_pops();
    write_all(8'hA5);
    write_all(8'h5A);
    for (int k = 0; k < 5 && !active[0]; k++) step();
    chk("pop_timeout", 0, int'(active[0]), 1);
    run(17);
    chk("tx_low_before_reset", 0, int'(txv[0]), 0);
    #2;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("async_rst_tx", i, int'(txv[i]), 1);
      chk("async_rst_busy", i, int'(busy[i]), 0);
      active[i] = 1'b0;
    end
    run(2);
    reset_n = 1'b1;
    clear_pops();
    run(60);
    check_pops("post_reset_pops", 1);
    for (int i = 0; i < NI; i++) chk("post_reset_word", i, int'(cur[i]), 'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
